// File: rtl/tick_pkg.sv
// Shared types for the tick SMA engine: window FSM states and the tick word type.
package tick_pkg;

    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic {FILL, STEADY} sma_state_e;

    typedef logic [DATA_W_DEF-1:0] tick_t;

endpackage

// File: rtl/sma_ring_buf.sv
// N-entry tick ring for the SMA window: write port, read of the slot about to be
// overwritten, and write-pointer / occupancy tracking.
module sma_ring_buf #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned WIN_LOG2 = 4
) (
    input  logic                clk_hifreq,
    input  logic                rst,
    input  logic                clear,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   rd_data,
    output logic [WIN_LOG2:0]   count
);

    localparam int unsigned N = 2 ** WIN_LOG2;
    localparam logic [WIN_LOG2:0] N_CNT = (WIN_LOG2 + 1)'(N);

    logic [DATA_W-1:0]   mem_q [N];
    logic [WIN_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [WIN_LOG2:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q != N_CNT) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_hifreq or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Contents need no reset: slots are only read once the window is primed.
    always_ff @(posedge clk_hifreq) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[wr_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/tick_sma_engine.sv
// Streaming simple-moving-average stage: running sum over the last 2**WIN_LOG2 ticks,
// one registered result per accepted tick with ready/valid handshakes on both sides.
module tick_sma_engine
    import tick_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned WIN_LOG2 = 4
) (
    input  logic              clk_hifreq,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_avg,
    output logic [DATA_W-1:0] out_raw,
    output logic              out_full
);

    localparam int unsigned SUM_W = DATA_W + WIN_LOG2;
    localparam int unsigned N     = 2 ** WIN_LOG2;
    localparam logic [WIN_LOG2:0] LAST_CNT = (WIN_LOG2 + 1)'(N - 1);

    sma_state_e        state_q, state_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_avg_q, out_avg_d;
    logic [DATA_W-1:0] out_raw_q, out_raw_d;
    logic              out_full_q, out_full_d;

    logic              accept;
    logic              last_tick;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] old_tick;
    logic [WIN_LOG2:0] count;

    sma_ring_buf #(
        .DATA_W   (DATA_W),
        .WIN_LOG2 (WIN_LOG2)
    ) u_ring (
        .clk_hifreq (clk_hifreq),
        .rst        (rst),
        .clear      (clear),
        .wr_en      (accept),
        .wr_data    (in_data),
        .rd_data    (rd_data),
        .count      (count)
    );

    assign in_ready  = !clear && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign last_tick = (count == LAST_CNT);
    // Evict the oldest tick only once the ring actually holds N of them.
    assign old_tick  = (state_q == STEADY) ? rd_data : '0;

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        out_avg_d   = out_avg_q;
        out_raw_d   = out_raw_q;
        out_full_d  = out_full_q;
        if (clear) begin
            state_d     = FILL;
            sum_d       = '0;
            out_valid_d = 1'b0;
            out_avg_d   = '0;
            out_raw_d   = '0;
            out_full_d  = 1'b0;
        end else if (accept) begin
            sum_d       = sum_q + SUM_W'(in_data) - SUM_W'(old_tick);
            out_valid_d = 1'b1;
            out_avg_d   = sum_d[SUM_W-1:WIN_LOG2];
            out_raw_d   = in_data;
            out_full_d  = (state_q == STEADY) || last_tick;
            if (state_q == FILL && last_tick) begin
                state_d = STEADY;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_hifreq or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_avg_q   <= '0;
            out_raw_q   <= '0;
            out_full_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            out_avg_q   <= out_avg_d;
            out_raw_q   <= out_raw_d;
            out_full_q  <= out_full_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_avg   = out_avg_q;
    assign out_raw   = out_raw_q;
    assign out_full  = out_full_q;

endmodule

// File: tb/tb_tick_sma_engine.sv
// Bench for tick_sma_engine (N=4): directed scenarios plus randomized handshakes
// checked against a queue-based moving-average model.
module tb_tick_sma_engine;

    localparam int unsigned DW  = 32;
    localparam int unsigned WL2 = 2;
    localparam int unsigned N   = 4;

    logic          clk_hifreq = 1'b0;
    logic          rst        = 1'b1;
    logic          clear      = 1'b0;
    logic          in_valid   = 1'b0;
    logic [DW-1:0] in_data    = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready  = 1'b0;
    logic [DW-1:0] out_avg;
    logic [DW-1:0] out_raw;
    logic          out_full;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] win_q[$];
    int            m_cnt;
    logic          m_valid;
    logic [DW-1:0] m_avg, m_raw;
    logic          m_full;

    tick_sma_engine #(
        .DATA_W   (DW),
        .WIN_LOG2 (WL2)
    ) dut (
        .clk_hifreq (clk_hifreq),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_avg    (out_avg),
        .out_raw    (out_raw),
        .out_full   (out_full)
    );

    always #5 clk_hifreq = ~clk_hifreq;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        win_q.delete();
        m_cnt   = 0;
        m_valid = 1'b0;
        m_avg   = '0;
        m_raw   = '0;
        m_full  = 1'b0;
    endtask

    task automatic model_push(input logic [DW-1:0] d);
        longint unsigned s;
        win_q.push_back(d);
        if (win_q.size() > N) void'(win_q.pop_front());
        s = 0;
        foreach (win_q[i]) s += longint'(win_q[i]);
        m_cnt++;
        m_avg   = DW'(s / N);
        m_raw   = d;
        m_full  = (m_cnt >= N);
        m_valid = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check_val({tag, ".avg"}, 64'(out_avg), 64'(m_avg));
            check_val({tag, ".raw"}, 64'(out_raw), 64'(m_raw));
            check_val({tag, ".full"}, 64'(out_full), 64'(m_full));
        end
    endtask

    // One clock cycle: drive inputs just after an edge, check in_ready, clock, check outputs.
    task automatic step(input string tag, input logic v, input logic [DW-1:0] d,
                        input logic ordy, input logic clr);
        logic exp_ready;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        #1;
        exp_ready = !clr && (!m_valid || ordy);
        check_val({tag, ".in_ready"}, 64'(in_ready), 64'(exp_ready));
        @(posedge clk_hifreq);
        if (clr) model_reset();
        else if (v && exp_ready) model_push(d);
        else if (m_valid && ordy) m_valid = 1'b0;
        #1;
        check_outputs(tag);
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic do_clear();
        step("clr", 1'b0, '0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] d;
        model_reset();
        #12;
        check_val("rst.valid", 64'(out_valid), 64'd0);
        check_val("rst.avg", 64'(out_avg), 64'd0);
        check_val("rst.full", 64'(out_full), 64'd0);
        rst = 1'b0;
        @(posedge clk_hifreq);
        #1;

        // Fill and steady
        step("fill0", 1'b1, 32'd10, 1'b1, 1'b0);
        check_val("fill0.avg_const", 64'(out_avg), 64'd2);
        step("fill1", 1'b1, 32'd20, 1'b1, 1'b0);
        step("fill2", 1'b1, 32'd30, 1'b1, 1'b0);
        step("fill3", 1'b1, 32'd40, 1'b1, 1'b0);
        check_val("fill3.full_const", 64'(out_full), 64'd1);
        step("fill4", 1'b1, 32'd50, 1'b1, 1'b0);
        check_val("fill4.avg_const", 64'(out_avg), 64'd35);

        // Wrap
        do_clear();
        for (int i = 1; i <= 9; i++) step("wrap", 1'b1, DW'(i), 1'b1, 1'b0);
        check_val("wrap.avg_const", 64'(out_avg), 64'd7);

        // Backpressure
        do_clear();
        step("bp0", 1'b1, 32'd10, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("bp_hold", 1'b1, 32'd20, 1'b0, 1'b0);
            check_val("bp_hold.avg_const", 64'(out_avg), 64'd2);
        end
        step("bp_rel", 1'b1, 32'd20, 1'b1, 1'b0);
        check_val("bp_rel.avg_const", 64'(out_avg), 64'd7);

        // Max values
        do_clear();
        for (int i = 0; i < 4; i++) step("max", 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        check_val("max.avg_const", 64'(out_avg), 64'hFFFF_FFFF);
        check_val("max.full_const", 64'(out_full), 64'd1);
        step("max_more", 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Clear mid-stream with a tick offered
        do_clear();
        step("cm0", 1'b1, 32'd10, 1'b1, 1'b0);
        step("cm1", 1'b1, 32'd20, 1'b1, 1'b0);
        step("cm2", 1'b1, 32'd30, 1'b1, 1'b0);
        step("cm_clr", 1'b1, 32'd99, 1'b1, 1'b1);
        check_val("cm_clr.valid_const", 64'(out_valid), 64'd0);
        step("cm3", 1'b1, 32'd8, 1'b1, 1'b0);
        check_val("cm3.avg_const", 64'(out_avg), 64'd2);
        check_val("cm3.full_const", 64'(out_full), 64'd0);

        // Async reset between edges while in STEADY
        do_clear();
        for (int i = 0; i < 5; i++) step("ar", 1'b1, DW'(100 + i), 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_val("ar.valid_now", 64'(out_valid), 64'd0);
        check_val("ar.avg_now", 64'(out_avg), 64'd0);
        check_val("ar.full_now", 64'(out_full), 64'd0);
        model_reset();
        @(posedge clk_hifreq);
        #4;
        rst = 1'b0;
        @(posedge clk_hifreq);
        #1;
        step("ar_post", 1'b1, 32'd40, 1'b1, 1'b0);
        check_val("ar_post.avg_const", 64'(out_avg), 64'd10);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: d = 32'hFFFF_FFFF - DW'($urandom_range(0, 3));
                1: d = DW'($urandom_range(0, 15));
                default: d = DW'($urandom);
            endcase
            step("rnd", ($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 99) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
